// File: rtl/booth_pp_accum.sv
// booth_pp_accum: sums the eight Booth partial products of a 16x16 multiply, LANES per cycle, behind valid/ready.
// Optional macro BOOTH_PP_ZERO_SKIP_EN: all-zero sets bypass ACC and zero tails end ACC early.
module booth_pp_accum #(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pp_1,
  input  logic [31:0] pp_2,
  input  logic [31:0] pp_3,
  input  logic [31:0] pp_4,
  input  logic [31:0] pp_5,
  input  logic [31:0] pp_6,
  input  logic [31:0] pp_7,
  input  logic [31:0] pp_8,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        busy
);
  localparam int NCYC = 8 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("booth_pp_accum: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t               state, state_nxt;
  logic [7:0][31:0]     pp_in, pp_q, pp_rest;
  logic [31:0]          acc, prod_q;
  logic [CW-1:0]        cnt;
  logic [LANES:0][31:0] psum;
  logic                 last_grp, zero_in;

  assign pp_in = {pp_8, pp_7, pp_6, pp_5, pp_4, pp_3, pp_2, pp_1};

  // Captured set is consumed from the bottom; the current group always sits in pp_q[LANES-1:0].
  assign pp_rest = pp_q >> (LANES * 32);
  assign psum[0] = acc;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign psum[l+1] = psum[l] + pp_q[l];
  end

`ifdef BOOTH_PP_ZERO_SKIP_EN
  assign zero_in  = (pp_in == '0);
  assign last_grp = (cnt == CW'(NCYC - 1)) || (pp_rest == '0);
`else
  assign zero_in  = 1'b0;
  assign last_grp = (cnt == CW'(NCYC - 1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = zero_in ? DONE : ACC;
      ACC:     if (last_grp) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pp_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          pp_q <= pp_in;
          acc  <= '0;
          cnt  <= '0;
          if (zero_in) prod_q <= '0;
        end
        ACC: begin
          acc  <= psum[LANES];
          pp_q <= pp_rest;
          cnt  <= cnt + 1'b1;
          if (last_grp) prod_q <= psum[LANES];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = prod_q;
endmodule

// File: tb/tb_booth_pp_accum.sv
// Bench for booth_pp_accum: four instances (LANES 1/2/4/8) share stimulus; the LANES=2 output feeds a scoreboard.
module tb_booth_pp_accum;
  logic             clk = 1'b0;
  logic             rst_n, in_valid, out_ready;
  logic [7:0][31:0] pp;
  logic [3:0]       ir, ov, bz;
  logic [3:0][31:0] pr;
  logic [31:0]      exp_q[$];
  int               n_chk = 0, n_pass = 0;

  typedef struct {
    logic [7:0][31:0] pp;
    logic [31:0]      exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    booth_pp_accum #(.LANES(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .pp_1(pp[0]), .pp_2(pp[1]), .pp_3(pp[2]), .pp_4(pp[3]),
      .pp_5(pp[4]), .pp_6(pp[5]), .pp_7(pp[6]), .pp_8(pp[7]),
      .out_valid(ov[g]), .out_ready(out_ready), .prod(pr[g]), .busy(bz[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Edges from accept edge to the first sample with out_valid high.
  function automatic int exp_lat(input logic [7:0][31:0] p, input int lanes);
`ifdef BOOTH_PP_ZERO_SKIP_EN
    int last = 0;
    for (int k = 0; k < 8; k++) if (p[k] != '0) last = k + 1;
    if (last == 0) return 0;
    return (last + lanes - 1) / lanes;
`else
    if (p === 'x) return -1;
    return 8 / lanes;
`endif
  endfunction

  // Scoreboard: a handoff on the LANES=2 instance happens at the posedge after this sample.
  always @(negedge clk) begin
    if (rst_n && ov[1] && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got %h expected no output", pr[1]);
      end else chk("sb_prod", pr[1], exp_q.pop_front());
    end
  end

  task automatic run_txn(input logic [7:0][31:0] v, input logic [31:0] e, input string nm);
    int lat[4];
    bit seen[4];
    for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; lat[g] = -1; end
    @(posedge clk); #1;
    pp = v; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++)
        if (!seen[g] && ov[g]) begin
          seen[g] = 1'b1;
          lat[g]  = t;
          chk($sformatf("%s_prod_L%0d", nm, 1 << g), pr[g], e);
        end
      if (t == 0) in_valid = 1'b0;
    end
    for (int g = 0; g < 4; g++)
      chk($sformatf("%s_lat_L%0d", nm, 1 << g), 32'(lat[g]), 32'(exp_lat(v, 1 << g)));
  endtask

  initial begin
    logic [7:0][31:0] va, vb, vr;
    logic [31:0]      ea, eb, er;

    for (int i = 0; i < 8; i++) begin tbl[i].pp = '0; tbl[i].exp = '0; end
    tbl[0].pp[0] = 32'h3;          tbl[0].pp[1] = 32'hC;          tbl[0].exp = 32'h0000000F;
    tbl[1].pp[0] = 32'h2;          tbl[1].pp[1] = 32'hFFFFFFFC;   tbl[1].exp = 32'hFFFFFFFE;
    for (int k = 0; k < 8; k++) tbl[2].pp[k] = 32'h80000000;       tbl[2].exp = 32'h0;
    tbl[4].pp[7] = 32'h00010000;                                   tbl[4].exp = 32'h00010000;
    tbl[5].pp[0] = 32'hFFFFFFFF;   tbl[5].pp[4] = 32'h00000100;   tbl[5].exp = 32'h000000FF;
    for (int i = 6; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        tbl[i].pp[k] = $urandom;
        tbl[i].exp   = tbl[i].exp + tbl[i].pp[k];
      end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pp = '0;
    #12;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_in_ready_L%0d", 1 << g), 32'(ir[g]), 32'h1);
      chk($sformatf("rst_out_valid_L%0d", 1 << g), 32'(ov[g]), 32'h0);
      chk($sformatf("rst_busy_L%0d", 1 << g), 32'(bz[g]), 32'h0);
      chk($sformatf("rst_prod_L%0d", 1 << g), pr[g], 32'h0);
    end
    #5 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i].pp, tbl[i].exp, $sformatf("vec%0d", i));

    // Backpressure: hold DONE, offer a new set meanwhile, then release.
    va = '0; va[0] = 32'h11; va[3] = 32'h2200; ea = 32'h2211;
    vb = '0; vb[1] = 32'h40; vb[6] = 32'h5000_0000; eb = 32'h5000_0040;
    @(posedge clk); #1;
    pp = va; in_valid = 1'b1; out_ready = 1'b0; exp_q.push_back(ea);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    pp = vb; in_valid = 1'b1; exp_q.push_back(eb);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_prod_stable", pr[1], ea);
      chk("bp_in_ready_low", 32'(ir[1]), 32'h0);
      chk("bp_out_valid_held", 32'(ov[1]), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_handoff", 32'(ir[1]), 32'h1);
    chk("bp_out_valid_dropped", 32'(ov[1]), 32'h0);
    @(posedge clk); #1;
    chk("bp_second_accept_busy", 32'(bz[1]), 32'h1);
    chk("bp_second_accept_in_ready", 32'(ir[1]), 32'h0);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset during ACC aborts; the LANES=8 instance is parked in DONE to see out_valid fall.
    vr = '0; for (int k = 0; k < 8; k++) vr[k] = 32'h0101_0101 * (k + 1); er = 32'h2424_2424;
    @(posedge clk); #1;
    pp = vr; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_L8_done_before", 32'(ov[3]), 32'h1);
    chk("rstmid_busy_before", 32'(bz[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_L8_out_valid", 32'(ov[3]), 32'h0);
    chk("rstmid_L8_prod", pr[3], 32'h0);
    chk("rstmid_out_valid", 32'(ov[1]), 32'h0);
    chk("rstmid_prod", pr[1], 32'h0);
    chk("rstmid_busy", 32'(bz[1]), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_in_ready_after", 32'(ir[1]), 32'h1);
    chk("rstmid_busy_after", 32'(bz[1]), 32'h0);
    run_txn(vr, er, "post_rst");

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Sequential consumer of the eight sign-extended radix-4 Booth partial products produced by the 16x16 Booth encoding stage.
- Accepts one set of eight 32-bit partial products through a valid/ready handshake and sums them over several cycles, LANES per cycle.
- Presents the 32-bit two's-complement product through a valid/ready output handshake.
- Sits between the Booth encoding stage and the multiplier result register. It is the area-lean alternative to a full Wallace compressor.

Parameters:
- LANES, 2, number of partial products added per cycle. Legal values are 1, 2, 4 and 8. NCYC = 8/LANES accumulate cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pp_1..pp_8 valid.
- in_ready  output  1  block can accept a new set.
- pp_1 .. pp_8  input  32 each  partial products, already sign-extended and shifted (pp_k weighted by 4^(k-1)).
- out_valid  output  1  prod valid.
- out_ready  input  1  downstream accepts prod.
- prod  output  32  sum of pp_1..pp_8 modulo 2^32.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - prod=0, accumulator=0, group counter=0.
  - Captured pp registers=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture all eight pp into internal registers, clear the accumulator, set the counter to 0, go to ACC.
  - in_ready drops in the cycle after accept.
- ACC:
  - in_ready=0.
  - Each edge adds captured pp[counter*LANES+1 .. counter*LANES+LANES] to the accumulator and increments the counter.
  - All additions are 32-bit, wrap-around modulo 2^32. No overflow flag; carries out of bit 31 are discarded.
  - On the edge that adds the last group (counter = NCYC-1): go to DONE and load prod with the final sum.
- DONE:
  - out_valid=1; prod is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - prod keeps its last value; it is only meaningful while out_valid=1.
- Latency:
  - Accept edge = edge k. out_valid is high after edge k+NCYC, i.e. NCYC+1 cycles from in_valid sampled.
  - With LANES=2: 4 accumulate edges.
- Throughput: one result per NCYC+2 cycles minimum, because in_ready returns only in the IDLE cycle after output handoff. Accept and output handoff never coincide.
- Input changes while in ACC/DONE are ignored; the captured copy is used.
- in_valid held high across a result returns is accepted again on the first IDLE edge.
- Reset mid-operation (ACC or DONE) aborts immediately:
  - out_valid falls asynchronously, the result is lost, no partial handshake completes.
  - After release, the block is in IDLE.
- Unsupported LANES values are rejected at elaboration (generate-time error).

Optional Feature:
- Macro: BOOTH_PP_ZERO_SKIP_EN.
- Defined:
  - At accept, if all eight pp are 32'h0, go directly to DONE with prod=0 on the accept edge, skipping ACC. out_valid is high 1 cycle after accept.
  - Additionally, the ACC state terminates early when all remaining uncaptured groups are zero. The final prod value is unchanged; only latency shrinks.
- Undefined: latency is always NCYC+1. Zero inputs traverse ACC normally.

Test Plan:
- LANES=2, xin=3, yin=5 encoding: pp_1=32'h3, pp_2=32'hC, pp_3..pp_8=0, in_valid pulse, out_ready=1 -> out_valid exactly 4 edges after accept, prod=32'h0000000F.
- xin=16'hFFFF, yin=2 encoding: pp_1=32'h2, pp_2=32'hFFFFFFFC, rest 0 -> prod=32'hFFFFFFFE (-2).
- All pp=32'h80000000 -> prod=32'h00000000 (wrap, no flag). Repeat with LANES=1, 4 and 8 -> out_valid after 8, 2 and 1 edges respectively.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changed pp -> prod stable, in_ready=0, no second accept. After out_ready=1, in_ready=1 in the next cycle and the new set is accepted.
- Assert rst_n=0 during ACC cycle 2 -> out_valid, prod and busy go to 0 immediately, in_ready=1 after release, next transaction yields the correct sum.
- BOOTH_PP_ZERO_SKIP_EN defined, all pp=0 -> out_valid 1 cycle after accept, prod=0. With the macro undefined, same stimulus -> 4 cycles.
